// File: rtl/weight_load_ctrl_if.sv
// Weight stream (valid/ready) and weight RAM write port for weight_load_ctrl.
// master: upstream/RAM side; slave: the controller.
interface weight_load_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output w_valid,
    output w_data,
    input  w_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  w_valid,
    input  w_data,
    output w_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// Writer-side controller for the conv weight buffer: streams KERNEL_SIZE words into RAM 0..N-1.
// Optional WEIGHT_LOAD_CHECKSUM_EN adds exp_sum/sum_err and gates weights_valid on a checksum.
module weight_load_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned KERNEL_SIZE = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_abort,
  weight_load_ctrl_if.slave     wif,
  output logic                  busy,
  output logic                  load_done,
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  input  logic [DATA_WIDTH+3:0] exp_sum,
  output logic                  sum_err,
`endif
  output logic                  weights_valid
);

  localparam logic [ADDR_WIDTH-1:0] LastCnt = ADDR_WIDTH'(KERNEL_SIZE - 1);

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  accept;

  assign busy        = (state_q == StLoad);
  assign wif.w_ready = busy && !load_abort;
  assign accept      = wif.w_valid && wif.w_ready;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH+3:0] sum_q;
  logic [DATA_WIDTH+3:0] sum_next;
  // Wraps naturally at 2^(DATA_WIDTH+4).
  assign sum_next = sum_q + {4'b0000, wif.w_data};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      wif.wr_en     <= 1'b0;
      wif.wr_addr   <= '0;
      wif.wr_data   <= '0;
      load_done     <= 1'b0;
      weights_valid <= 1'b0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
      sum_q         <= '0;
      sum_err       <= 1'b0;
`endif
    end else begin
      wif.wr_en <= 1'b0;
      load_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Abort outranks a simultaneous start.
          if (load_start && !load_abort) begin
            state_q       <= StLoad;
            cnt_q         <= '0;
            weights_valid <= 1'b0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
            sum_q         <= '0;
            sum_err       <= 1'b0;
`endif
          end
        end
        StLoad: begin
          if (load_abort) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (accept) begin
            wif.wr_en   <= 1'b1;
            wif.wr_addr <= cnt_q;
            wif.wr_data <= wif.w_data;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
            sum_q       <= sum_next;
`endif
            if (cnt_q == LastCnt) begin
              state_q   <= StIdle;
              cnt_q     <= '0;
              load_done <= 1'b1;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
              sum_err       <= (sum_next != exp_sum);
              weights_valid <= (sum_next == exp_sum);
`else
              weights_valid <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: directed steps plus randomized traffic against
// a queue-based reference model of the load protocol.
module tb_weight_load_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned KS = 9;

  logic clk = 1'b0;
  logic reset;
  logic load_start, load_abort;
  logic busy, load_done, weights_valid;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [DW+3:0] exp_sum;
  logic          sum_err;
`endif

  weight_load_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wif ();

  weight_load_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .KERNEL_SIZE(KS)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_start    (load_start),
    .load_abort    (load_abort),
    .wif           (wif.slave),
    .busy          (busy),
    .load_done     (load_done),
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    .exp_sum       (exp_sum),
    .sum_err       (sum_err),
`endif
    .weights_valid (weights_valid)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: words accepted in the current load, plus observable levels.
  logic [DW-1:0] m_words[$];
  bit            m_loading = 0;
  bit            m_wv = 0;
  bit            m_sum_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int unsigned   n_writes = 0;
  int unsigned   n_dones = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_words.delete();
    m_loading = 0;
    m_wv      = 0;
    m_sum_err = 0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  // One clock cycle: drive at negedge, check ready, then check registered outputs after posedge.
  task automatic step(input bit start, input bit abort, input bit valid, input logic [DW-1:0] d);
    bit exp_en   = 0;
    bit exp_done = 0;
    int sum      = 0;
    @(negedge clk);
    load_start  = start;
    load_abort  = abort;
    wif.w_valid = valid;
    wif.w_data  = d;
    #1;
    check("w_ready", 32'(wif.w_ready), 32'(m_loading && !abort));
    check("busy", 32'(busy), 32'(m_loading));
    if (!m_loading) begin
      if (start && !abort) begin
        m_loading = 1;
        m_words.delete();
        m_wv      = 0;
        m_sum_err = 0;
      end
    end else if (abort) begin
      m_loading = 0;
    end else if (valid) begin
      exp_en = 1;
      m_addr = AW'(m_words.size());
      m_data = d;
      m_words.push_back(d);
      if (m_words.size() == KS) begin
        m_loading = 0;
        exp_done  = 1;
        foreach (m_words[i]) sum += int'(m_words[i]);
        sum = sum % (1 << (DW + 4));
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        m_sum_err = (sum != int'(exp_sum));
        m_wv      = !m_sum_err;
`else
        m_wv      = (sum >= 0);
`endif
      end
    end
    @(posedge clk);
    #1;
    if (wif.wr_en === 1'b1) n_writes++;
    if (load_done === 1'b1) n_dones++;
    check("wr_en", 32'(wif.wr_en), 32'(exp_en));
    check("wr_addr", 32'(wif.wr_addr), 32'(m_addr));
    check("wr_data", 32'(wif.wr_data), 32'(m_data));
    check("load_done", 32'(load_done), 32'(exp_done));
    check("weights_valid", 32'(weights_valid), 32'(m_wv));
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    check("sum_err", 32'(sum_err), 32'(m_sum_err));
`endif
  endtask

  initial begin
    int gaps[4] = '{0, 2, 1, 3};
    int w0;
    int d0;
    reset       = 1'b0;
    load_start  = 1'b0;
    load_abort  = 1'b0;
    wif.w_valid = 1'b0;
    wif.w_data  = '0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    exp_sum = 12'd126;
`endif
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(wif.wr_en), 32'd0);
    check("rst_wr_addr", 32'(wif.wr_addr), 32'd0);
    check("rst_wr_data", 32'(wif.wr_data), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_weights_valid", 32'(weights_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Back-to-back words 10..18.
    step(1, 0, 0, '0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, DW'(10 + i));
    step(0, 0, 0, '0);
    check("b2b_writes", n_writes, 32'd9);
    check("b2b_done", n_dones, 32'd1);

    // Gaps between words; load_start drops weights_valid.
    n_writes = 0;
    step(1, 0, 0, '0);
    check("start_clears_wv", 32'(weights_valid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      for (int g = 0; g < gaps[i % 4]; g++) step(0, 0, 0, DW'($urandom));
      step(0, 0, 1, DW'($urandom));
    end
    step(0, 0, 0, '0);
    check("gap_writes", n_writes, 32'd9);

    // Abort after 4 accepts with w_valid high.
    n_writes = 0;
    n_dones  = 0;
    step(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'($urandom));
    step(0, 1, 1, 8'hee);
    step(0, 0, 1, 8'hdd);
    check("abort_writes", n_writes, 32'd4);
    check("abort_done", n_dones, 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // Start+abort together in IDLE: stays idle.
    step(1, 1, 0, '0);
    check("start_abort_idle", 32'(busy), 32'd0);

    // Start mid-load is ignored (addresses keep counting).
    step(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, DW'(i));
    step(1, 0, 1, 8'h55);
    check("midstart_addr", 32'(wif.wr_addr), 32'd3);
    for (int i = 0; i < 5; i++) step(0, 0, 1, DW'(i));
    check("midstart_done", 32'(load_done), 32'd1);

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    // Checksum pass then fail.
    exp_sum = 12'd45;
    step(1, 0, 0, '0);
    for (int i = 1; i <= 9; i++) step(0, 0, 1, DW'(i));
    check("cks_ok_err", 32'(sum_err), 32'd0);
    exp_sum = 12'd44;
    step(1, 0, 0, '0);
    for (int i = 1; i <= 9; i++) step(0, 0, 1, DW'(i));
    check("cks_bad_err", 32'(sum_err), 32'd1);
    check("cks_bad_wv", 32'(weights_valid), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
`ifdef WEIGHT_LOAD_CHECKSUM_EN
      if ($urandom_range(0, 15) == 0) exp_sum = 12'($urandom);
`endif
      w0 = int'($urandom_range(0, 2));
      d0 = int'($urandom_range(0, 19));
      step($urandom_range(0, 5) == 0, d0 == 0, w0 != 0, DW'($urandom));
    end

    // Asynchronous reset at cnt=5.
    step(0, 1, 0, '0);
    step(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, DW'(i + 100));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_wr_en", 32'(wif.wr_en), 32'd0);
    check("arst_wr_addr", 32'(wif.wr_addr), 32'd0);
    check("arst_wr_data", 32'(wif.wr_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wv", 32'(weights_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fresh load after reset starts at address 0.
    step(1, 0, 0, '0);
    step(0, 0, 1, 8'h42);
    check("post_rst_addr", 32'(wif.wr_addr), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, DW'($urandom));
    step(0, 0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
